lct_frame_rx: RTL

- Receiving end of the two-frame LCT link that carries the trigger block's best/second-best wire-group results (hv/hp/hnp/hfap/hpatbp, lv/lp/lnp/lfap/lpatbp) plus shower_int and a 2-bit BX tag.
- Aligns to the 16-bit frame stream, checks per-frame parity and reconstructs the LCT fields with a one-cycle strobe.
- Used on the loopback/test path and on the consuming board; also counts link errors.

---
 rtl/lct_frame_rx_if.sv | 40 ++++
 rtl/lct_frame_rx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lct_frame_rx_if.sv
// Frame bus into the LCT link receiver and the decoded best/second LCT fields
// coming out of it, bundled so producer and consumer share one declaration.
interface lct_frame_rx_if #(
    parameter int ERRW = 16
);
    logic [15:0]     lct_in;
    logic            err_clr;

    logic            hv;
    logic [1:0]      hp;
    logic [6:0]      hnp;
    logic            hfap;
    logic            hpatbp;

    logic            lv;
    logic [1:0]      lp;
    logic [6:0]      lnp;
    logic            lfap;
    logic            lpatbp;

    logic [1:0]      shower_int;
    logic [1:0]      bxn;
    logic            lct_strobe;
    logic            locked;
    logic [ERRW-1:0] err_cnt;

    modport master (
        output lct_in, err_clr,
        input  hv, hp, hnp, hfap, hpatbp,
        input  lv, lp, lnp, lfap, lpatbp,
        input  shower_int, bxn, lct_strobe, locked, err_cnt
    );

    modport slave (
        input  lct_in, err_clr,
        output hv, hp, hnp, hfap, hpatbp,
        output lv, lp, lnp, lfap, lpatbp,
        output shower_int, bxn, lct_strobe, locked, err_cnt
    );
endinterface

// File: rtl/lct_frame_rx.sv
// Receiving end of the two-frame LCT link: aligns to frame pairs, checks parity,
// locks after a run of good pairs and emits the decoded LCT fields with a strobe.
module lct_frame_rx #(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_MAX   = 3,
    parameter int ERRW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lct_frame_rx_if.slave link
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     r0;
    logic [15:0]     r1;
    logic            phase;
    logic [GW-1:0]   good_cnt;
    logic [MW-1:0]   miss_cnt;
    logic [11:0]     best_q;
    logic [11:0]     second_q;
    logic [1:0]      shower_q;
    logic [1:0]      bxn_q;
    logic            strobe_q;
    logic            locked_q;
    logic [ERRW-1:0] err_q;

    logic            r0_par_ok;
    logic            r1_par_ok;
    logic            marker_ok;
    logic            pair_good;
    logic            count_err;

    // phase=1 means r0 holds frame 1 and r1 holds frame 0 of the same pair
    always_comb begin
        r0_par_ok = ~^r0;
        r1_par_ok = ~^r1;
        marker_ok = r0[15] & r0_par_ok;
        pair_good = r1[15] & ~r0[15] & r0_par_ok & r1_par_ok;
        count_err = phase & ~pair_good & (state != HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            r0       <= '0;
            r1       <= '0;
            phase    <= 1'b0;
            good_cnt <= '0;
            miss_cnt <= '0;
            best_q   <= '0;
            second_q <= '0;
            shower_q <= '0;
            bxn_q    <= '0;
            strobe_q <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            r0       <= link.lct_in;
            r1       <= r0;
            strobe_q <= 1'b0;
            phase    <= (state == HUNT) ? marker_ok : ~phase;

            if (link.err_clr) begin
                err_q <= '0;
            end else if (count_err && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end

            case (state)
                HUNT: begin
                    if (phase && pair_good) begin
                        state    <= CHECK;
                        good_cnt <= GW'(1);
                    end
                end
                CHECK: begin
                    if (phase) begin
                        if (!pair_good) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                            // the locking pair itself is not emitted
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good_cnt <= '0;
                            miss_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (phase) begin
                        if (pair_good) begin
                            miss_cnt <= '0;
                            strobe_q <= 1'b1;
                            best_q   <= r1[14:3];
                            second_q <= r0[14:3];
                            shower_q <= r1[2:1];
                            bxn_q    <= r0[2:1];
                        end else if (miss_cnt == MW'(MISS_MAX - 1)) begin
                            state    <= HUNT;
                            locked_q <= 1'b0;
                            miss_cnt <= '0;
                            best_q   <= '0;
                            second_q <= '0;
                            shower_q <= '0;
                            bxn_q    <= '0;
                        end else begin
                            miss_cnt    <= miss_cnt + 1'b1;
                            best_q[11]   <= 1'b0;
                            second_q[11] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    assign {link.hv, link.hp, link.hnp, link.hfap, link.hpatbp} = best_q;
    assign {link.lv, link.lp, link.lnp, link.lfap, link.lpatbp} = second_q;
    assign link.shower_int = shower_q;
    assign link.bxn        = bxn_q;
    assign link.lct_strobe = strobe_q;
    assign link.locked     = locked_q;
    assign link.err_cnt    = err_q;
endmodule
